// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB
// operand forwarding feeding the ALU and the store-data path.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_alusrc,
  input  logic [2:0]        id_aluop,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_illegal_op
);

  logic              valid_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic              alusrc_q;
  logic [2:0]        aluop_q;
  logic              regwrite_q, memread_q, memwrite_q, memtoreg_q;
  logic              illegal_q;
  logic              bubble, load, op_undef;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    hazard_stall = 1'b0;
    if (!stall && !flush && valid_q && memread_q && (rd_q != '0))
      hazard_stall = (rd_q == id_rs) || ((rd_q == id_rt) && !id_alusrc);
  end

  // hazard_stall is already masked by stall, so flush still outranks stall here
  assign bubble   = flush || hazard_stall;
  assign load     = !bubble && !stall;
  assign op_undef = (id_aluop == 3'd4) || (id_aluop == 3'd5) || (id_aluop == 3'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bubble) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (load) begin
      valid_q    <= id_valid;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
      alusrc_q   <= id_alusrc;
      aluop_q    <= id_aluop;
      regwrite_q <= id_regwrite & id_valid;
      memread_q  <= id_memread  & id_valid;
      memwrite_q <= id_memwrite & id_valid;
      memtoreg_q <= id_memtoreg & id_valid;
      if (id_valid && op_undef)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = aluop_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = regwrite_q & valid_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q & valid_q;
  assign ex_memtoreg   = memtoreg_q;
  assign ex_illegal_op = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX snapshots are queued when ID is
// driven and popped for comparison one edge later.
module tb_id_ex_stage;

  logic        clk, rst, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_alusrc;
  logic [2:0]  id_aluop;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        hazard_stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, mt, ill;
  } exp_t;

  exp_t sb[$];

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_illegal_op(ex_illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [31:0] sd, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input logic mt,
                              input logic ill);
    exp_t e;
    e.valid = v; e.a = a; e.b = b; e.op = op; e.sd = sd; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.mt = mt; e.ill = ill;
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, ex_valid, e.valid);
      chk({tag, "_a"}, alu_a, e.a);
      chk({tag, "_b"}, alu_b, e.b);
      chk({tag, "_op"}, alu_op, e.op);
      chk({tag, "_sd"}, ex_store_data, e.sd);
      chk({tag, "_rd"}, ex_rd, e.rd);
      chk({tag, "_rw"}, ex_regwrite, e.rw);
      chk({tag, "_mr"}, ex_memread, e.mr);
      chk({tag, "_mw"}, ex_memwrite, e.mw);
      chk({tag, "_mt"}, ex_memtoreg, e.mt);
      chk({tag, "_ill"}, ex_illegal_op, e.ill);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [15:0] imm, input logic src, input logic [2:0] op,
                       input logic rw, input logic mr, input logic mw, input logic mt);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = src; id_aluop = op;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_out("reset");
    #10 rst = 1'b0;

    // 1: add r3 = r1 + r2
    drive(1, 1, 2, 3, 32'd5, 32'd7, 16'h0000, 0, 3'd2, 1, 0, 0, 0);
    sb.push_back(mk(1, 32'd5, 32'd7, 3'd2, 32'd7, 5'd3, 1, 0, 0, 0, 0));
    step();
    check_out("add");

    // 2: forwarding priority on rs=1
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'hBB;
    #1 chk("fwd_exmem", alu_a, 32'hAA);
    chk("fwd_rt_none", ex_store_data, 32'd7);
    exmem_regwrite = 1'b0;
    #1 chk("fwd_memwb", alu_a, 32'hBB);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0;
    #1 chk("fwd_exmem_r0", alu_a, 32'hBB);
    memwb_rd = 5'd2;
    #1 chk("fwd_rt_memwb_b", alu_b, 32'hBB);
    chk("fwd_rt_memwb_sd", ex_store_data, 32'hBB);
    chk("fwd_rs_plain", alu_a, 32'd5);
    clear_fwd();

    // 3: lw r4 then a consumer of r4
    drive(1, 1, 0, 4, 32'd5, 32'd0, 16'd8, 1, 3'd2, 1, 1, 0, 1);
    sb.push_back(mk(1, 32'd5, 32'd8, 3'd2, 32'd0, 5'd4, 1, 1, 0, 1, 0));
    step();
    check_out("lw");
    drive(1, 4, 5, 6, 32'h11, 32'h22, 16'h0000, 0, 3'd2, 1, 0, 0, 0);
    #1 chk("hazard_on", hazard_stall, 1'b1);
    stall = 1'b1;
    #1 chk("hazard_masked_stall", hazard_stall, 1'b0);
    stall = 1'b0;
    flush = 1'b1;
    #1 chk("hazard_masked_flush", hazard_stall, 1'b0);
    flush = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check_out("hazard_bubble");
    chk("hazard_off", hazard_stall, 1'b0);
    sb.push_back(mk(1, 32'h11, 32'h22, 3'd2, 32'h22, 5'd6, 1, 0, 0, 0, 0));
    step();
    check_out("consumer");

    // 4: stall holds through changing ID inputs, then flush beats stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 7), 5'(i + 8), 5'(i + 9), 32'(100 + i), 32'(200 + i),
            16'(i), 1, 3'd1, 0, 1, 1, 1);
      sb.push_back(mk(1, 32'h11, 32'h22, 3'd2, 32'h22, 5'd6, 1, 0, 0, 0, 0));
      step();
      check_out("stall_hold");
    end
    flush = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check_out("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // 5: sign-extended immediate, store forwarding, undefined ALUop
    drive(1, 0, 2, 7, 32'h33, 32'h44, 16'hFFF0, 1, 3'd5, 0, 0, 1, 0);
    sb.push_back(mk(1, 32'h33, 32'hFFFFFFF0, 3'd5, 32'h44, 5'd7, 0, 0, 1, 0, 1));
    step();
    check_out("imm_illegal");
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd2; memwb_result = 32'hBB;
    #1 chk("r0_no_fwd", alu_a, 32'h33);
    chk("imm_b_kept", alu_b, 32'hFFFFFFF0);
    chk("store_fwd", ex_store_data, 32'hBB);
    clear_fwd();
    // invalid ID: controls gated, sticky flag retained
    drive(0, 1, 2, 3, 32'd9, 32'hA, 16'h0000, 0, 3'd0, 1, 0, 1, 0);
    sb.push_back(mk(0, 32'd9, 32'hA, 3'd0, 32'hA, 5'd3, 0, 0, 0, 0, 1));
    step();
    check_out("invalid_gated");

    // 6: asynchronous reset between edges
    drive(1, 1, 2, 4, 32'd1, 32'd2, 16'd4, 1, 3'd2, 1, 1, 0, 1);
    sb.push_back(mk(1, 32'd1, 32'd4, 3'd2, 32'd2, 5'd4, 1, 1, 0, 1, 1));
    step();
    check_out("pre_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", ex_valid, 1'b0);
    chk("arst_rw", ex_regwrite, 1'b0);
    chk("arst_mr", ex_memread, 1'b0);
    chk("arst_mt", ex_memtoreg, 1'b0);
    chk("arst_rd", ex_rd, 5'd0);
    chk("arst_op", alu_op, 3'd0);
    chk("arst_ill", ex_illegal_op, 1'b0);
    #3 rst = 1'b0;
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
